time_surface_scan_controller: RTL and testbench

Sequences full-grid readout of the exponential-decay time surface encoder for the feature-extraction stage. On a start request it freezes the encoder's `t_now`, sweeps every cell address, and realigns the encoder's fixed 2-cycle read latency into a valid/ready stream. A credit-counted skid FIFO absorbs downstream backpressure. It sits between the global timestamp counter, the time surface encoder's read port and the flatten/feature block.

---
 rtl/ts_scan_pkg.sv | 23 ++
 rtl/ts_scan_fifo.sv | 53 +++++
 rtl/time_surface_scan_controller.sv | 178 +++++++++++++++++
 tb/tb_time_surface_scan_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_scan_pkg.sv
// Shared types and default sizing for the time-surface grid scan controller.
package ts_scan_pkg;

    localparam int DEF_GRID_SIZE    = 16;
    localparam int DEF_ADDR_BITS    = 8;
    localparam int DEF_TS_BITS      = 16;
    localparam int DEF_VALUE_BITS   = 8;
    localparam int DEF_READ_LATENCY = 2;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0]  addr;
        logic [DEF_VALUE_BITS-1:0] value;
    } ts_scan_entry_t;

endpackage

// File: rtl/ts_scan_fifo.sv
// Small first-word-fall-through FIFO; the head entry is visible on pop_data whenever !empty.
module ts_scan_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [CNT_BITS-1:0] count_q;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_BITS'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; the consumer gates the head with empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/time_surface_scan_controller.sv
// Sweeps the time-surface encoder grid against a frozen t_now and streams {addr, value}
// through a credit-counted skid FIFO. Define TS_SCAN_STATS_EN for sum/max/active-count outputs.
module time_surface_scan_controller
    import ts_scan_pkg::*;
#(
    parameter int GRID_SIZE    = DEF_GRID_SIZE,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int TS_BITS      = DEF_TS_BITS,
    parameter int VALUE_BITS   = DEF_VALUE_BITS,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TS_BITS-1:0]    t_global,
    output logic                  busy,
    output logic                  done,
    output logic [TS_BITS-1:0]    ts_t_now,
    output logic                  ts_read_enable,
    output logic [ADDR_BITS-1:0]  ts_read_addr,
    input  logic [VALUE_BITS-1:0] ts_read_value,
    output logic                  feat_valid,
    input  logic                  feat_ready,
    output logic [ADDR_BITS-1:0]  feat_addr,
    output logic [VALUE_BITS-1:0] feat_value,
    output logic                  feat_last
`ifdef TS_SCAN_STATS_EN
    ,
    output logic [VALUE_BITS+ADDR_BITS-1:0] stat_sum,
    output logic [VALUE_BITS-1:0]           stat_max,
    output logic [ADDR_BITS:0]              stat_active
`endif
);

    localparam int N        = GRID_SIZE * GRID_SIZE;
    localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;
    localparam int EW       = ADDR_BITS + VALUE_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N - 1);

    scan_state_t          state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [TS_BITS-1:0]   t_now_q, t_now_d;
    logic                 issue;
    logic [31:0]          inflight;
    logic                 credit_ok;

    logic [READ_LATENCY-1:0] tag_vld;
    logic [EW-1:0]           fifo_wdata;
    logic [EW-1:0]           fifo_rdata;
    logic [CNT_BITS-1:0]     fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_pop;

    // Tag pipe mirrors the encoder latency so each returning value carries its address.
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
        logic                 v_q;
        logic [ADDR_BITS-1:0] a_q;
        logic                 v_in;
        logic [ADDR_BITS-1:0] a_in;
        if (gi == 0) begin : g_head
            assign v_in = issue;
            assign a_in = addr_q;
        end else begin : g_body
            assign v_in = g_tag[gi-1].v_q;
            assign a_in = g_tag[gi-1].a_q;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                a_q <= '0;
            end else begin
                v_q <= v_in;
                a_q <= a_in;
            end
        end
        assign tag_vld[gi] = v_q;
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + 32'(tag_vld[i]);
    end

    // Outstanding reads are counted against FIFO space, so a push can never find it full.
    assign credit_ok  = !fifo_full && ((32'(fifo_count) + inflight) < 32'(FIFO_DEPTH));
    assign fifo_wdata = {g_tag[READ_LATENCY-1].a_q, ts_read_value};
    assign fifo_pop   = feat_valid && feat_ready;

    ts_scan_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_vld[READ_LATENCY-1]),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign feat_valid = !fifo_empty;
    assign feat_addr  = fifo_empty ? '0 : fifo_rdata[VALUE_BITS +: ADDR_BITS];
    assign feat_value = fifo_empty ? '0 : fifo_rdata[VALUE_BITS-1:0];
    assign feat_last  = !fifo_empty && (feat_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            t_now_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            t_now_q <= t_now_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        t_now_d = t_now_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                t_now_d = t_global;
                addr_d  = '0;
                if (start) state_d = SCAN;
            end
            SCAN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (addr_q == LAST_ADDR) state_d = DRAIN;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            // The last-cell handshake implies the tag pipe and FIFO have fully drained.
            DRAIN: begin
                if (fifo_pop && feat_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign ts_read_enable = (state_q == SCAN) || (state_q == DRAIN);
    assign ts_read_addr   = addr_q;
    assign ts_t_now       = t_now_q;

`ifdef TS_SCAN_STATS_EN
    logic [EW-1:0]         sum_q;
    logic [VALUE_BITS-1:0] max_q;
    logic [ADDR_BITS:0]    active_q;

    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start)) begin
            sum_q    <= '0;
            max_q    <= '0;
            active_q <= '0;
        end else if (fifo_pop) begin
            sum_q <= sum_q + EW'(feat_value);
            if (feat_value > max_q)  max_q    <= feat_value;
            if (feat_value != '0)    active_q <= active_q + 1'b1;
        end
    end

    assign stat_sum    = sum_q;
    assign stat_max    = max_q;
    assign stat_active = active_q;
`endif

endmodule

// File: tb/tb_time_surface_scan_controller.sv
// Bench for time_surface_scan_controller: encoder model, table of scan scenarios, scoreboard
// of expected beats, plus reset corner sequences. Stats checks active under TS_SCAN_STATS_EN.
`timescale 1ns/1ps
module tb_time_surface_scan_controller;
    import ts_scan_pkg::*;

    localparam int N     = 256;
    localparam int LIMIT = 4000;
    localparam int NVEC  = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] t_global;
    logic        busy;
    logic        done;
    logic [15:0] ts_t_now;
    logic        ts_read_enable;
    logic [7:0]  ts_read_addr;
    logic [7:0]  ts_read_value;
    logic        feat_valid;
    logic        feat_ready;
    logic [7:0]  feat_addr;
    logic [7:0]  feat_value;
    logic        feat_last;
`ifdef TS_SCAN_STATS_EN
    logic [15:0] stat_sum;
    logic [7:0]  stat_max;
    logic [8:0]  stat_active;
`endif

    always #5 clk = ~clk;

    time_surface_scan_controller dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .t_global       (t_global),
        .busy           (busy),
        .done           (done),
        .ts_t_now       (ts_t_now),
        .ts_read_enable (ts_read_enable),
        .ts_read_addr   (ts_read_addr),
        .ts_read_value  (ts_read_value),
        .feat_valid     (feat_valid),
        .feat_ready     (feat_ready),
        .feat_addr      (feat_addr),
        .feat_value     (feat_value),
        .feat_last      (feat_last)
`ifdef TS_SCAN_STATS_EN
        ,
        .stat_sum       (stat_sum),
        .stat_max       (stat_max),
        .stat_active    (stat_active)
`endif
    );

    int vec_count = 0;
    int err_count = 0;
    int cur_vec   = -1;

    task automatic check(input string name, input int act, input int exp_v);
        vec_count++;
        if (act != exp_v) begin
            err_count++;
            $display("FAIL %s (scenario %0d): got %0d, expected %0d", name, cur_vec, act, exp_v);
        end
    endtask

    // Encoder model: 2-cycle read, value = 255 >> (dt >> 6), zero once the shift reaches 8.
    logic [15:0] cell_ts [N];
    bit          cell_wr [N];
    logic [7:0]  enc_addr_q;
    logic [7:0]  enc_val_q;

    function automatic logic [7:0] enc_value(input logic [7:0] a, input logic [15:0] tnow);
        logic [15:0] dt;
        logic [15:0] s;
        if (!cell_wr[a]) return 8'd0;
        dt = tnow - cell_ts[a];
        s  = dt >> 6;
        if (s >= 16'd8) return 8'd0;
        return 8'(16'd255 >> s);
    endfunction

    always @(posedge clk) begin
        enc_addr_q <= ts_read_addr;
        enc_val_q  <= enc_value(enc_addr_q, ts_t_now);
    end
    assign ts_read_value = enc_val_q;

    // Scoreboard monitor on the falling edge.
    ts_scan_entry_t sb [$];
    ts_scan_entry_t mon_e;
    bit             mon_en = 1'b0;
    bit             stall_pending = 1'b0;
    logic [7:0]     held_addr;
    logic [7:0]     held_value;
    int             beats = 0;
    int             done_pulses = 0;

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (!mon_en) begin
            stall_pending = 1'b0;
        end else if (feat_valid) begin
            if (stall_pending) begin
                check("stall_addr_stable", int'(feat_addr), int'(held_addr));
                check("stall_value_stable", int'(feat_value), int'(held_value));
            end
            if (feat_ready) begin
                beats++;
                stall_pending = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_beat_addr", int'(feat_addr), -1);
                end else begin
                    mon_e = sb.pop_front();
                    check("beat_addr", int'(feat_addr), int'(mon_e.addr));
                    check("beat_value", int'(feat_value), int'(mon_e.value));
                    check("beat_last", int'(feat_last), int'(mon_e.addr == 8'd255));
                end
            end else begin
                stall_pending = 1'b1;
                held_addr     = feat_addr;
                held_value    = feat_value;
            end
        end else if (stall_pending) begin
            check("valid_held_while_stalled", int'(feat_valid), 1);
            stall_pending = 1'b0;
        end
    end

    typedef struct {
        int write_ts;
        int t_start;
        int t_step;
        int ready_pct;
        bit extra_start;
        int n_written;
        int exp_value;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check_reset_outputs();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_read_enable", int'(ts_read_enable), 0);
        check("rst_read_addr", int'(ts_read_addr), 0);
        check("rst_feat_valid", int'(feat_valid), 0);
        check("rst_feat_last", int'(feat_last), 0);
        check("rst_feat_addr", int'(feat_addr), 0);
        check("rst_feat_value", int'(feat_value), 0);
        check("rst_t_now", int'(ts_t_now), 0);
    endtask

    task automatic load_cells(input int wts, input int nw, input int expv);
        ts_scan_entry_t e;
        sb.delete();
        for (int i = 0; i < N; i++) begin
            cell_wr[i] = (i < nw);
            cell_ts[i] = 16'(wts);
            e.addr     = 8'(i);
            e.value    = (i < nw) ? 8'(expv) : 8'd0;
            sb.push_back(e);
        end
    endtask

    // Entered and left #1 after a rising edge.
    task automatic run_scan(input int idx);
        vec_t v;
        int   cyc;
        int   first_valid;
        int   dp0;
        v       = vecs[idx];
        cur_vec = idx;
        load_cells(v.write_ts, v.n_written, v.exp_value);
        dp0        = done_pulses;
        beats      = 0;
        t_global   = 16'(v.t_start);
        feat_ready = ($urandom_range(0, 99) < v.ready_pct);
        start      = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        cyc         = 1;
        first_valid = -1;
        check("busy_after_start", int'(busy), 1);
        check("first_read_addr", int'(ts_read_addr), 0);
        check("read_enable_in_scan", int'(ts_read_enable), 1);
        while (!done && cyc < LIMIT) begin
            if (feat_valid && first_valid < 0) first_valid = cyc;
            t_global   = t_global + 16'(v.t_step);
            feat_ready = ($urandom_range(0, 99) < v.ready_pct);
            start      = v.extra_start && (cyc == 10 || cyc == 200);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("done_within_budget", int'(done), 1);
        if (v.ready_pct == 100) check("done_cycle", cyc, 260);
        check("first_valid_cycle", first_valid, 4);
        check("busy_in_done", int'(busy), 1);
        check("t_now_frozen", int'(ts_t_now), v.t_start);
        check("all_beats_received", sb.size(), 0);
        check("beat_count", beats, N);
`ifdef TS_SCAN_STATS_EN
        check("stat_sum", int'(stat_sum), v.n_written * v.exp_value);
        check("stat_max", int'(stat_max), (v.n_written > 0) ? v.exp_value : 0);
        check("stat_active", int'(stat_active), (v.exp_value != 0) ? v.n_written : 0);
`endif
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
        check("busy_cleared", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulse_count", done_pulses - dp0, 1);
    endtask

    initial begin
        int cyc;
        int dp0;
        // {write_ts, t_start, t_step, ready_pct, extra_start, n_written, exp_value}
        vecs[0] = '{100,   100, 0, 100, 1'b0, 256, 255}; // free flow
        vecs[1] = '{0,     600, 4, 100, 1'b0, 256, 0};   // dt 600 -> shift 9 -> 0
        vecs[2] = '{0,     200, 4, 100, 1'b0, 256, 31};  // dt 200 -> shift 3
        vecs[3] = '{65500, 100, 1, 100, 1'b0, 256, 63};  // wrapped dt 136 -> shift 2
        vecs[4] = '{100,   164, 3, 30,  1'b0, 256, 127}; // backpressure, dt 64 -> shift 1
        vecs[5] = '{100,   100, 0, 100, 1'b1, 256, 255}; // start pulses while busy
        vecs[6] = '{50,    50,  0, 100, 1'b0, 4,   255}; // four live cells

        rst        = 1'b1;
        start      = 1'b0;
        t_global   = 16'd1234;
        feat_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            cell_wr[i] = 1'b0;
            cell_ts[i] = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        cur_vec = -1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;
        check("t_now_tracks", int'(ts_t_now), 1234);
        t_global = 16'd77;
        @(posedge clk); #1;
        check("t_now_tracks_next", int'(ts_t_now), 77);
        check("idle_busy", int'(busy), 0);
        check("idle_read_enable", int'(ts_read_enable), 0);
        mon_en = 1'b1;

        // Reset beats a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", int'(busy), 0);
        @(posedge clk); #1;
        check("rst_start_busy_later", int'(busy), 0);
        check("rst_start_read_enable", int'(ts_read_enable), 0);

        for (int i = 0; i < NVEC; i++) run_scan(i);

        // Reset after 77 accepted beats, then a clean full scan.
        cur_vec = 100;
        load_cells(100, 256, 255);
        dp0        = done_pulses;
        beats      = 0;
        t_global   = 16'd100;
        feat_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (beats < 77 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_beat_77", beats, 77);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs();
        sb.delete();
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_no_done", done_pulses - dp0, 0);
        run_scan(0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
